alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Parametrised, multi-cycle multiply/divide execution unit implementing the RV32M operation set alongside the single-cycle ALU in the EX stage. It accepts one operation at a time over a valid/ready handshake and iterates one bit per cycle: shift-add for multiply, restoring division for divide. Division special cases complete on a fast path. It returns a registered result plus status flags that hold until the pipeline consumes them.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 4).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand; multiplicand / dividend.
- b  in  WIDTH  rs2 operand; multiplier / divisor.
- flush  in  1  abort the in-flight operation (pipeline kill).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- div_zero  out  1  divide op with b == 0.
- ovf  out  1  signed divide overflow: a = MIN, b = −1.
- illegal  out  1  divide op issued with divide compiled out.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On the edge with in_valid & !flush:
  - latch op, sign flags, and operand magnitudes (a and b become independent of later input changes);
  - load counter = WIDTH−1 and go to CALC.
  - Exception: a divide special case goes directly to DONE instead.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Signed operands are converted to magnitudes at accept.
- CALC: one iteration per edge on an unsigned 2·WIDTH product, or on a quotient/remainder pair. When counter==0 on an edge, go to FIX; otherwise decrement.
- FIX: apply sign correction, then go to DONE.
  - Product sign = sign_a ^ sign_b. Negate the full 2·WIDTH product before selecting the half.
  - Quotient sign = sign_a ^ sign_b. Remainder sign = sign_a.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
  - zero is computed from the final result.
- Divide special cases (fast path, IDLE→DONE):
  - b==0: DIV/DIVU result = all ones; REM/REMU result = a; div_zero=1.
  - DIV/REM with a = 1 followed by WIDTH−1 zeros and b = all ones: DIV result = a, REM result = 0; ovf=1.
- DONE: out_valid=1. result and flags are held stable while out_ready=0. On the edge with out_ready=1, go to IDLE.
- flush:
  - Any state → IDLE on the edge where flush=1. out_valid drops and results are discarded.
  - In IDLE, flush & in_valid on the same edge: flush wins and the request is not accepted.
- rst: highest priority, from any state at any point, including mid-CALC.
- Reset values: state IDLE; in_ready 1 after reset; out_valid 0; result 0; zero 0; div_zero 0; ovf 0; illegal 0; counter 0.

## Timing
- Normal op: accept edge E0; iterations on E1..E_WIDTH; FIX on E_WIDTH; DONE after E_WIDTH+1.
  - out_valid is high WIDTH+1 edges after accept (33 for WIDTH=32).
- Fast path: out_valid is high 1 edge after accept.
- Minimum spacing between back-to-back operations: one IDLE cycle after the DONE→IDLE edge.
- All outputs are registered. There is no combinational path from in_valid/a/b to any output; in_ready depends only on state.

## Configuration
- MULDIV_DIV_EN defined: full divide/remainder hardware as above; illegal is always 0.
- MULDIV_DIV_EN undefined:
  - no divider datapath;
  - ops 1xx take the fast path with result=0, illegal=1, div_zero=0, ovf=0;
  - multiply ops are unchanged.

## Test plan
- MUL a=7, b=6 -> result 0x0000002A, zero=0; out_valid rises exactly 33 edges after accept; in_ready=0 throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV 5/0 -> 0xFFFFFFFF, div_zero=1, out_valid after 1 edge; REMU 5/0 -> 0x00000005.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, ovf=1; REM same operands -> 0, zero=1, ovf=1.
- Hold out_ready=0 for 10 cycles in DONE -> result and flags stable. Then:
  - flush at cycle 5 of CALC -> IDLE next edge, out_valid never rises, next op correct;
  - rst mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional divider hardware is enabled by defining MULDIV_DIV_EN; without it divide ops report illegal.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero,
  output logic             ovf,
  output logic             illegal,
  output logic [1:0]       dbg_state
);
  // Handshake: a request is taken on an edge where in_valid & in_ready & !flush; a result is
  // presented while out_valid is high and consumed on an edge where out_valid & out_ready.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, div_zero_q, div_zero_d;
  logic               ovf_q, ovf_d, illegal_q, illegal_d;

  logic               a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_full;
  logic [WIDTH-1:0]   fix_res;

  assign a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign b_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign neg_a    = a_signed & a[WIDTH-1];
  assign neg_b    = b_signed & b[WIDTH-1];
  assign a_abs    = neg_a ? (~a + 1'b1) : a;
  assign b_abs    = neg_b ? (~b + 1'b1) : b;

  // Multiply: {hi, lo} starts as {0, multiplier}; add multiplicand into hi when lo[0] is set, shift right.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_full = (sign_a_q ^ sign_b_q) ? (~prod_q + 1'b1) : prod_q;

`ifdef MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Divide: {rem, quo} starts as {0, dividend}; quotient bits shift in from the right.
  assign rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];
  assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                            : ((op_q[1:0] == 2'b00) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH]);
`else
  assign fix_res  = (op_q[1:0] == 2'b00) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    illegal_d  = illegal_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_d       = op;
          sign_a_d   = neg_a;
          sign_b_d   = neg_b;
          cnt_d      = CW'(WIDTH - 1);
          opnd_d     = op[2] ? b_abs : a_abs;
          prod_d     = {{WIDTH{1'b0}}, (op[2] ? a_abs : b_abs)};
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
          illegal_d  = 1'b0;
          state_d    = CALC;
`ifdef MULDIV_DIV_EN
          if (op[2] && (b == '0)) begin
            state_d    = DONE;
            result_d   = op[1] ? a : '1;
            zero_d     = op[1] && (a == '0);
            div_zero_d = 1'b1;
          end else if (op[2] && !op[0] && (a == MIN_VAL) && (b == '1)) begin
            state_d  = DONE;
            result_d = op[1] ? '0 : a;
            zero_d   = op[1];
            ovf_d    = 1'b1;
          end
`else
          if (op[2]) begin
            state_d   = DONE;
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
          end
`endif
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          prod_d = op_q[2] ? div_next : mul_next;
`else
          prod_d = mul_next;
`endif
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
        FIX: begin
          result_d = fix_res;
          zero_d   = (fix_res == '0);
          state_d  = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      opnd_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq (WIDTH=32): vector table plus flush, hold and reset sequences.
// Divide expectations follow whether MULDIV_DIV_EN is defined for the build.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, div_zero, ovf, illegal;
  logic [1:0]   dbg_state;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .div_zero(div_zero), .ovf(ovf), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, dz, ov, ill;
    bit           fast;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] vop, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input logic [W-1:0] vres, input logic vz, input logic vdz, input logic vov,
                     input bit vfast);
    vec_t v;
    v.op = vop; v.a = va; v.b = vb; v.res = vres; v.z = vz; v.dz = vdz; v.ov = vov;
    v.ill = 1'b0; v.fast = vfast;
`ifndef MULDIV_DIV_EN
    if (vop[2]) begin
      v.res = '0; v.z = 1'b1; v.dz = 1'b0; v.ov = 1'b0; v.ill = 1'b1; v.fast = 1'b1;
    end
`endif
    vecs.push_back(v);
  endtask

  // Issue one op, wait for the result, compare, optionally stall the consumer, then retire it.
  task automatic run_vec(input vec_t v, input string tag, input bit hold);
    int           edges;
    bit           ready_low;
    logic [W-1:0] exp_res;
    chk({tag, "_ready_before"}, in_ready, 1);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    exp_q.push_back(v.res);
    tick();
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    edges = 0;
    ready_low = 1'b1;
    while (!out_valid && edges < 100) begin
      if (in_ready) ready_low = 1'b0;
      tick();
      edges++;
    end
    // Out_valid is high right after the accept edge on the fast path, W+1 edges later otherwise.
    chk({tag, "_latency"}, edges, v.fast ? 0 : W + 1);
    chk({tag, "_ready_low"}, ready_low, 1);
    exp_res = exp_q.pop_front();
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_zero"}, zero, v.z);
    chk({tag, "_div_zero"}, div_zero, v.dz);
    chk({tag, "_ovf"}, ovf, v.ov);
    chk({tag, "_illegal"}, illegal, v.ill);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        chk($sformatf("%s_hold%0d_valid", tag, i), out_valid, 1);
        chk($sformatf("%s_hold%0d_result", tag, i), result, exp_res);
        chk($sformatf("%s_hold%0d_flags", tag, i), {zero, div_zero, ovf, illegal},
            {v.z, v.dz, v.ov, v.ill});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_retired_valid"}, out_valid, 0);
    chk({tag, "_retired_ready"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit never_valid;

    add(3'b000, 32'd7,        32'd6,        32'h0000002A, 0, 0, 0, 0);
    add(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 0, 0);
    add(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0);
    add(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    add(3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 0, 0, 0, 0);
    add(3'b000, 32'h12345678, 32'd0,        32'h00000000, 1, 0, 0, 0);
    add(3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 0, 0, 0);
    add(3'b011, 32'h80000000, 32'd4,        32'h00000002, 0, 0, 0, 0);
    add(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 0, 0);
    add(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 0, 0);
    add(3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 0, 0, 0, 0);
    add(3'b111, 32'hFFFFFFF9, 32'd2,        32'h00000001, 0, 0, 0, 0);
    add(3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0, 0, 0, 0);
    add(3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 0, 0, 0, 0);
    add(3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 0, 0, 0, 0);
    add(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1, 0, 1);
    add(3'b111, 32'd5,        32'd0,        32'h00000005, 0, 1, 0, 1);
    add(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 1, 1);
    add(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1, 1);

    repeat (3) tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {zero, div_zero, ovf, illegal}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("post_reset_state", dbg_state, 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

    run_vec(vecs[0], "hold_mul", 1'b1);
    run_vec(vecs[16], "hold_remu0", 1'b1);

    // Flush during CALC: the aborted op must never produce a result.
    in_valid = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("flush_in_calc", dbg_state, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    never_valid = 1'b1;
    repeat (40) begin tick(); if (out_valid) never_valid = 1'b0; end
    chk("flush_never_valid", never_valid, 1);
    run_vec(vecs[2], "after_flush", 1'b0);

    // Flush and in_valid together: request is dropped.
    in_valid = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_valid_ready", in_ready, 1);
    never_valid = 1'b1;
    repeat (40) begin tick(); if (out_valid) never_valid = 1'b0; end
    chk("flush_vs_valid_never", never_valid, 1);

    // Reset mid-CALC, with a nonzero result still held from the previous op.
    in_valid = 1'b1; op = 3'b000; a = 32'd7; b = 32'd6;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_flags", {zero, div_zero, ovf, illegal}, 4'b0000);
    chk("rst_mid_state", dbg_state, 0);
    run_vec(vecs[3], "after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
